// File: rtl/bcd_pkg.sv
// bcd_pkg: FSM state encodings, digit width and sizing helpers shared by score_bcd_conv.
package bcd_pkg;
  localparam int DIG_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
  function automatic int dec_digits(input int bits);
    longint p = 1;
    int d = 0;
    while (p < (longint'(1) << bits)) begin
      p = p * 10;
      d++;
    end
    return d;
  endfunction
  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the digit is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] nib_in,
  output logic [DIG_W-1:0] nib_out
);
  always_comb nib_out = (nib_in >= DIG_W'(5)) ? nib_in + DIG_W'(3) : nib_in;
endmodule

// File: rtl/score_bcd_conv.sv
// score_bcd_conv: sequential double-dabble binary-to-BCD converter for score digits.
// Define SCORE_BCD_CLAMP_EN to saturate out-of-range inputs to all 9s instead of wrapping.
module score_bcd_conv
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     digit_out
);
  localparam int ACC_D = (dec_digits(BIN_W) > DIGITS) ? dec_digits(BIN_W) : DIGITS;
  localparam int ACC_W = ACC_D * DIG_W;
  localparam int OUT_W = DIGITS * DIG_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  state_e                 state_q, state_d;
  logic [BIN_W-1:0]       sr_q, sr_d, load_val;
  logic [ACC_W-1:0]       acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0]       dout_q, dout_d;
  logic [ACC_W+BIN_W-1:0] shifted;
  for (genvar g = 0; g < ACC_D; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in (acc_q[g*DIG_W +: DIG_W]),
      .nib_out(acc_adj[g*DIG_W +: DIG_W])
    );
  end
`ifdef SCORE_BCD_CLAMP_EN
  localparam longint MAX_V = pow10(DIGITS) - 1;
  always_comb load_val = (64'(bin_in) > MAX_V) ? BIN_W'(MAX_V) : bin_in;
`else
  always_comb load_val = bin_in;
`endif
  // digit_out only moves on the final step, so a frame never sees a partial result
  always_comb begin
    shifted = {acc_adj, sr_q} << 1;
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    if (state_q == SHIFT) begin
      {acc_d, sr_d} = shifted;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(BIN_W - 1)) begin
        state_d = DONE;
        dout_d  = shifted[BIN_W +: OUT_W];
      end
    end else if (start) begin
      sr_d    = load_val;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = SHIFT;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end
  always_comb begin
    busy      = (state_q == SHIFT);
    done      = (state_q == DONE);
    digit_out = dout_q;
  end
endmodule
